keypad_matrix_scanner: RTL and testbench
========================================

Name: keypad_matrix_scanner

Overview:
Input-side counterpart to the LED matrix column driver. It drives the columns of a passive switch keypad one at a time, reads the row lines back, debounces the result over whole scans, and emits a debounced key code with a one-cycle valid pulse. It sits beside the existing button and switch conditioning and feeds the system FSMs. It runs on fast_clock.

Parameters:
- ROWS, 4: number of row sense lines.
- COLS, 4: number of column drive lines.
- SCAN_DIVIDER, 1000: clock cycles each column stays driven (≥2).
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release (≥1).

Ports:
- clock  input  1  fast clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- scan_enable  input  1  high = scanning active.
- row_sense  input  ROWS  raw keypad rows, active-low (pulled up), asynchronous to clock.
- col_drive  output  COLS  one-hot-low column strobe; all ones = no column driven.
- key_code  output  CODE_W  row*COLS+col of accepted key; CODE_W = clog2(ROWS*COLS).
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high from acceptance until the release is accepted.
- multi_key  output  1  high while the latest completed scan saw more than one key.

Behaviour:
- Reset (async): col_drive = all ones, key_code = 0, key_valid = 0, key_held = 0, multi_key = 0, state = IDLE, all counters and snapshots cleared.
- Row input: two-flop synchroniser on row_sense, inverted internally to active-high before use.
- Column sequencing:
  - With scan_enable high, column 0 is driven on the first cycle.
  - Each column is held for SCAN_DIVIDER cycles. The order is 0 → COLS-1, then wraps to 0.
  - Full scan period = COLS*SCAN_DIVIDER cycles.
- Sampling: the synchronised rows are captured on the last cycle of each column slot, giving SCAN_DIVIDER-1 cycles of settling plus sync delay. Captured bits go into a ROWS*COLS snapshot at bit index row*COLS+col.
- Scan completion: a scan completes at the sample of column COLS-1. All FSM decisions are made only on scan-complete cycles.
- Snapshot classification: EMPTY (0 bits set), SINGLE (1 bit set, code = its index), MULTI (>1 bit set).
- multi_key updates on every scan complete.
- FSM states and transitions:
  - IDLE:
    - SINGLE → DEBOUNCE_PRESS with candidate = code and count = 1.
    - Otherwise stay in IDLE.
  - DEBOUNCE_PRESS:
    - SINGLE with the same code → count+1.
    - Any other result (EMPTY, MULTI, or a different code) → back to IDLE and count cleared; no carry-over to the new code.
    - When count reaches DEBOUNCE_SCANS → PRESSED. In that same cycle: key_code ← candidate, key_valid = 1, key_held = 1.
    - With DEBOUNCE_SCANS = 1, the first SINGLE scan goes directly IDLE → PRESSED.
  - PRESSED:
    - EMPTY → DEBOUNCE_RELEASE with count = 1.
    - SINGLE (same or other key) or MULTI → stay in PRESSED. There is no rollover: a second key is ignored until all keys are released.
  - DEBOUNCE_RELEASE:
    - EMPTY → count+1.
    - Anything non-EMPTY → back to PRESSED, with no new key_valid.
    - When count reaches DEBOUNCE_SCANS → IDLE and key_held = 0.
- Outputs during operation:
  - key_code holds its value after release until the next acceptance.
  - key_valid is high for exactly one cycle per accepted press.
- Latency: for a clean press that is stable before scan N starts, key_valid asserts on the scan-complete cycle of scan N+DEBOUNCE_SCANS-1. Press-to-pulse latency is at most (DEBOUNCE_SCANS+1)*COLS*SCAN_DIVIDER + 2 cycles.
- scan_enable low:
  - Next cycle: col_drive = all ones, state = IDLE, key_held = 0, multi_key = 0, counters and the partial snapshot cleared, key_code held, no key_valid.
  - On re-enable, scanning restarts at column 0 with a fresh scan.
- Reset mid-scan or mid-debounce: returns immediately to the reset values. A key still held afterwards is re-debounced from scratch.
- Counter widths must be sized to hold SCAN_DIVIDER-1 and DEBOUNCE_SCANS without overflow. The column index wraps modulo COLS.

Decomposition:
- Shared header keypad_defs: FSM state encodings (IDLE, DEBOUNCE_PRESS, PRESSED, DEBOUNCE_RELEASE) and the CODE_W derivation.
- Sub-module keypad_column_driver: slot-cycle divider, one-hot column rotator, and the sample/scan_complete strobes.
- keypad_matrix_scanner owns the synchroniser, the snapshot, classification, and the FSM.

Test Plan:
All cases use ROWS=4, COLS=4, SCAN_DIVIDER=4, DEBOUNCE_SCANS=3, so one scan = 16 cycles.
- Reset then scan_enable=1, no keys → col_drive cycles 1110, 1101, 1011, 0111 every 4 cycles; key_valid never asserts; key_held=0.
- Key row 2/col 1 held solid → key_code=9, one key_valid pulse on the 3rd scan-complete after the press is seen; key_held=1. Release for 3 scans → key_held=0 and key_code stays 9.
- Bouncing key (present 2 scans, absent 1, present 3) → exactly one key_valid, after the final 3-scan run; no pulse earlier.
- Keys 0 and 5 pressed together → multi_key=1 and no key_valid. Release key 5 → key 0 accepted after 3 scans with key_code=0 and multi_key=0.
- While key 3 is held, also press key 12, then release only key 3 → no new key_valid and key_held stays 1; key 12 is reported only after a full release and a fresh press.
- Assert reset, or drop scan_enable, mid-DEBOUNCE_PRESS → col_drive=1111 and state=IDLE. After resume with the key still held, key_valid fires after 3 fresh scans.

Source files
------------

// File: rtl/keypad_defs.sv
// Shared FSM state encodings and width helpers for the keypad scanner.
package keypad_defs;
    localparam logic [1:0] ST_IDLE             = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED          = 2'd2;
    localparam logic [1:0] ST_DEBOUNCE_RELEASE = 2'd3;

    // Bits needed to index n items (at least one bit).
    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/keypad_column_driver.sv
// Slot divider and one-hot-low column rotator; raises sample on the last cycle of
// each column slot and scan_complete on the sample of the final column.
module keypad_column_driver
    import keypad_defs::*;
#(
    parameter int COLS         = 4,
    parameter int SCAN_DIVIDER = 1000,
    localparam int COL_W       = width_of(COLS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             scan_enable,
    output logic [COLS-1:0]  col_drive,
    output logic [COL_W-1:0] col_index,
    output logic             sample,
    output logic             scan_complete
);
    localparam int SLOT_W = width_of(SCAN_DIVIDER);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIVIDER - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);

    logic              running;
    logic [SLOT_W-1:0] slot_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            running    <= 1'b0;
            slot_count <= '0;
            col_index  <= '0;
        end else if (!scan_enable) begin
            running    <= 1'b0;
            slot_count <= '0;
            col_index  <= '0;
        end else begin
            running <= 1'b1;
            if (running) begin
                if (slot_count == SLOT_LAST) begin
                    slot_count <= '0;
                    col_index  <= (col_index == COL_LAST) ? '0 : col_index + 1'b1;
                end else begin
                    slot_count <= slot_count + 1'b1;
                end
            end
        end
    end

    assign sample        = running && scan_enable && (slot_count == SLOT_LAST);
    assign scan_complete = sample && (col_index == COL_LAST);

    always_comb begin
        col_drive = '1;
        if (running) col_drive[col_index] = 1'b0;
    end
endmodule

// File: rtl/keypad_matrix_scanner.sv
// Keypad scanner: synchronises rows, builds a per-scan snapshot and debounces it over
// whole scans; key_valid pulses the cycle after the accepting scan completes.
module keypad_matrix_scanner
    import keypad_defs::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIVIDER   = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    localparam int CODE_W        = width_of(ROWS * COLS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              scan_enable,
    input  logic [ROWS-1:0]   row_sense,
    output logic [COLS-1:0]   col_drive,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              multi_key
);
    localparam int KEYS  = ROWS * COLS;
    localparam int COL_W = width_of(COLS);
    localparam int CNT_W = width_of(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [COL_W-1:0]  col_index;
    logic              sample;
    logic              scan_complete;
    logic [ROWS-1:0]   row_meta;
    logic [ROWS-1:0]   row_sync;
    logic [KEYS-1:0]   snapshot;
    logic [KEYS-1:0]   scan_bits;
    logic              any_hit;
    logic              many_hit;
    logic              single;
    logic [CODE_W-1:0] hit_code;
    logic [CODE_W-1:0] candidate;
    logic [CNT_W-1:0]  count;
    logic [1:0]        state;

    keypad_column_driver #(
        .COLS         (COLS),
        .SCAN_DIVIDER (SCAN_DIVIDER)
    ) u_cols (
        .clock         (clock),
        .reset         (reset),
        .scan_enable   (scan_enable),
        .col_drive     (col_drive),
        .col_index     (col_index),
        .sample        (sample),
        .scan_complete (scan_complete)
    );

    // Rows idle high through the pull-ups, so the synchroniser resets to all ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_sense;
            row_sync <= row_meta;
        end
    end

    // Snapshot with the column currently being sampled merged in.
    always_comb begin
        scan_bits = snapshot;
        for (int k = 0; k < KEYS; k++) begin
            if (k % COLS == int'(col_index)) scan_bits[k] = ~row_sync[k / COLS];
        end
    end

    always_comb begin
        any_hit  = 1'b0;
        many_hit = 1'b0;
        hit_code = '0;
        for (int k = 0; k < KEYS; k++) begin
            if (scan_bits[k]) begin
                if (any_hit) many_hit = 1'b1;
                any_hit  = 1'b1;
                hit_code = CODE_W'(k);
            end
        end
    end

    assign single = any_hit && !many_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            candidate <= '0;
            snapshot  <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (!scan_enable) begin
                state     <= ST_IDLE;
                count     <= '0;
                candidate <= '0;
                snapshot  <= '0;
                key_held  <= 1'b0;
                multi_key <= 1'b0;
            end else begin
                if (sample) snapshot <= scan_bits;
                if (scan_complete) begin
                    multi_key <= many_hit;
                    case (state)
                        ST_IDLE: begin
                            if (single) begin
                                candidate <= hit_code;
                                if (DEBOUNCE_SCANS == 1) begin
                                    state     <= ST_PRESSED;
                                    count     <= '0;
                                    key_code  <= hit_code;
                                    key_valid <= 1'b1;
                                    key_held  <= 1'b1;
                                end else begin
                                    state <= ST_DEBOUNCE_PRESS;
                                    count <= CNT_W'(1);
                                end
                            end
                        end
                        ST_DEBOUNCE_PRESS: begin
                            if (single && hit_code == candidate) begin
                                if (count == CNT_LAST) begin
                                    state     <= ST_PRESSED;
                                    count     <= '0;
                                    key_code  <= candidate;
                                    key_valid <= 1'b1;
                                    key_held  <= 1'b1;
                                end else begin
                                    count <= count + 1'b1;
                                end
                            end else begin
                                state <= ST_IDLE;
                                count <= '0;
                            end
                        end
                        ST_PRESSED: begin
                            // Extra keys are ignored until everything is released.
                            if (!any_hit) begin
                                if (DEBOUNCE_SCANS == 1) begin
                                    state    <= ST_IDLE;
                                    key_held <= 1'b0;
                                end else begin
                                    state <= ST_DEBOUNCE_RELEASE;
                                    count <= CNT_W'(1);
                                end
                            end
                        end
                        ST_DEBOUNCE_RELEASE: begin
                            if (!any_hit) begin
                                if (count == CNT_LAST) begin
                                    state    <= ST_IDLE;
                                    count    <= '0;
                                    key_held <= 1'b0;
                                end else begin
                                    count <= count + 1'b1;
                                end
                            end else begin
                                state <= ST_PRESSED;
                                count <= '0;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: directed scan tables plus random scans against a scan-level model.
module tb_keypad_matrix_scanner;
    localparam int DS = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        scan_enable;
    logic [3:0]  row_sense;
    logic [3:0]  col_drive;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        multi_key;
    logic [15:0] keys;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] keys;
        logic        valid;
        logic        held;
        logic        multi;
        logic [3:0]  code;
    } vec_t;

    vec_t vec[$];

    // Scan-level reference model state.
    int         m_press_run;
    int         m_rel_run;
    int         m_cand;
    logic       m_held;
    logic       m_multi;
    logic       m_valid;
    logic [3:0] m_code;

    keypad_matrix_scanner #(
        .ROWS           (4),
        .COLS           (4),
        .SCAN_DIVIDER   (4),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .scan_enable (scan_enable),
        .row_sense   (row_sense),
        .col_drive   (col_drive),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .multi_key   (multi_key)
    );

    always #5 clock = ~clock;

    // Passive switch matrix: a row is pulled low by any pressed key on a driven column.
    always_comb begin
        row_sense = '1;
        for (int r = 0; r < 4; r++) row_sense[r] = ~|(keys[r*4 +: 4] & ~col_drive);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] k, input logic v, input logic h,
                                input logic m, input logic [3:0] c);
        vec_t t;
        t.keys = k; t.valid = v; t.held = h; t.multi = m; t.code = c;
        return t;
    endfunction

    // Holds keys for one whole scan, ending on the negedge after its scan-complete edge.
    task automatic run_scan(input logic [15:0] k);
        int stray;
        int col_err;
        logic [3:0] exp_col;
        stray = 0;
        col_err = 0;
        keys = k;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clock);
            exp_col = ~(4'b0001 << ((j / 4) % 4));
            if (col_drive !== exp_col) col_err++;
            if (j < 16 && key_valid !== 1'b0) stray++;
        end
        check("col_sequence", col_err, 0);
        check("no_stray_valid", stray, 0);
    endtask

    task automatic apply(input vec_t v, input string tag);
        run_scan(v.keys);
        check({tag, "_valid"}, key_valid, v.valid);
        check({tag, "_held"},  key_held,  v.held);
        check({tag, "_multi"}, multi_key, v.multi);
        check({tag, "_code"},  key_code,  v.code);
    endtask

    task automatic model_reset();
        m_press_run = 0; m_rel_run = 0; m_cand = 0;
        m_held = 0; m_multi = 0; m_valid = 0; m_code = 0;
    endtask

    task automatic model_scan(input logic [15:0] k);
        int n;
        int code;
        n = $countones(k);
        code = 0;
        for (int i = 0; i < 16; i++) if (k[i]) code = i;
        m_valid = 0;
        m_multi = (n > 1);
        if (!m_held) begin
            if (n == 1 && m_press_run > 0 && code == m_cand) m_press_run++;
            else if (n == 1 && m_press_run == 0) begin
                m_cand = code;
                m_press_run = 1;
            end else m_press_run = 0;
            if (m_press_run == DS) begin
                m_valid = 1; m_held = 1; m_code = 4'(m_cand);
                m_press_run = 0; m_rel_run = 0;
            end
        end else begin
            m_rel_run = (n == 0) ? m_rel_run + 1 : 0;
            if (m_rel_run == DS) begin
                m_held = 0; m_rel_run = 0;
            end
        end
    endtask

    logic [15:0] prev_keys;
    logic [15:0] rnd_keys;
    int          r;

    initial begin
        reset = 1'b1;
        scan_enable = 1'b0;
        keys = '0;

        // Idle, row 2/col 1, bounce, two-key, and no-rollover sequences.
        vec.push_back(mk(16'h0000, 0, 0, 0, 4'd0));
        vec.push_back(mk(16'h0000, 0, 0, 0, 4'd0));
        vec.push_back(mk(16'h0200, 0, 0, 0, 4'd0));
        vec.push_back(mk(16'h0200, 0, 0, 0, 4'd0));
        vec.push_back(mk(16'h0200, 1, 1, 0, 4'd9));
        vec.push_back(mk(16'h0200, 0, 1, 0, 4'd9));
        vec.push_back(mk(16'h0000, 0, 1, 0, 4'd9));
        vec.push_back(mk(16'h0000, 0, 1, 0, 4'd9));
        vec.push_back(mk(16'h0000, 0, 0, 0, 4'd9));
        vec.push_back(mk(16'h0040, 0, 0, 0, 4'd9));
        vec.push_back(mk(16'h0040, 0, 0, 0, 4'd9));
        vec.push_back(mk(16'h0000, 0, 0, 0, 4'd9));
        vec.push_back(mk(16'h0040, 0, 0, 0, 4'd9));
        vec.push_back(mk(16'h0040, 0, 0, 0, 4'd9));
        vec.push_back(mk(16'h0040, 1, 1, 0, 4'd6));
        vec.push_back(mk(16'h0000, 0, 1, 0, 4'd6));
        vec.push_back(mk(16'h0000, 0, 1, 0, 4'd6));
        vec.push_back(mk(16'h0000, 0, 0, 0, 4'd6));
        vec.push_back(mk(16'h0021, 0, 0, 1, 4'd6));
        vec.push_back(mk(16'h0021, 0, 0, 1, 4'd6));
        vec.push_back(mk(16'h0001, 0, 0, 0, 4'd6));
        vec.push_back(mk(16'h0001, 0, 0, 0, 4'd6));
        vec.push_back(mk(16'h0001, 1, 1, 0, 4'd0));
        vec.push_back(mk(16'h0000, 0, 1, 0, 4'd0));
        vec.push_back(mk(16'h0000, 0, 1, 0, 4'd0));
        vec.push_back(mk(16'h0000, 0, 0, 0, 4'd0));
        vec.push_back(mk(16'h0008, 0, 0, 0, 4'd0));
        vec.push_back(mk(16'h0008, 0, 0, 0, 4'd0));
        vec.push_back(mk(16'h0008, 1, 1, 0, 4'd3));
        vec.push_back(mk(16'h1008, 0, 1, 1, 4'd3));
        vec.push_back(mk(16'h1000, 0, 1, 0, 4'd3));
        vec.push_back(mk(16'h1000, 0, 1, 0, 4'd3));
        vec.push_back(mk(16'h0000, 0, 1, 0, 4'd3));
        vec.push_back(mk(16'h0000, 0, 1, 0, 4'd3));
        vec.push_back(mk(16'h0000, 0, 0, 0, 4'd3));
        vec.push_back(mk(16'h1000, 0, 0, 0, 4'd3));
        vec.push_back(mk(16'h1000, 0, 0, 0, 4'd3));
        vec.push_back(mk(16'h1000, 1, 1, 0, 4'd12));
        vec.push_back(mk(16'h0000, 0, 1, 0, 4'd12));
        vec.push_back(mk(16'h0000, 0, 1, 0, 4'd12));
        vec.push_back(mk(16'h0000, 0, 0, 0, 4'd12));

        repeat (3) @(negedge clock);
        check("rst_col_drive", col_drive, 4'hF);
        check("rst_key_code",  key_code,  4'h0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held",  key_held,  1'b0);
        check("rst_multi_key", multi_key, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check("disabled_col_drive", col_drive, 4'hF);
        scan_enable = 1'b1;
        @(negedge clock);

        for (int i = 0; i < vec.size(); i++) apply(vec[i], $sformatf("vec%0d", i));

        // Reset in the middle of press debounce, key kept down.
        apply(mk(16'h0200, 0, 0, 0, 4'd12), "pre_rst0");
        apply(mk(16'h0200, 0, 0, 0, 4'd12), "pre_rst1");
        reset = 1'b1;
        #1;
        check("midrst_col_drive", col_drive, 4'hF);
        check("midrst_key_code",  key_code,  4'h0);
        check("midrst_key_held",  key_held,  1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        apply(mk(16'h0200, 0, 0, 0, 4'd0), "post_rst0");
        apply(mk(16'h0200, 0, 0, 0, 4'd0), "post_rst1");
        apply(mk(16'h0200, 1, 1, 0, 4'd9), "post_rst2");
        apply(mk(16'h0000, 0, 1, 0, 4'd9), "post_rst3");
        apply(mk(16'h0000, 0, 1, 0, 4'd9), "post_rst4");
        apply(mk(16'h0000, 0, 0, 0, 4'd9), "post_rst5");

        // scan_enable dropped in the middle of press debounce.
        apply(mk(16'h0020, 0, 0, 0, 4'd9), "pre_dis0");
        apply(mk(16'h0020, 0, 0, 0, 4'd9), "pre_dis1");
        scan_enable = 1'b0;
        @(negedge clock);
        check("dis_col_drive", col_drive, 4'hF);
        check("dis_key_held",  key_held,  1'b0);
        check("dis_multi_key", multi_key, 1'b0);
        check("dis_key_valid", key_valid, 1'b0);
        check("dis_key_code",  key_code,  4'd9);
        scan_enable = 1'b1;
        @(negedge clock);
        apply(mk(16'h0020, 0, 0, 0, 4'd9), "post_dis0");
        apply(mk(16'h0020, 0, 0, 0, 4'd9), "post_dis1");
        apply(mk(16'h0020, 1, 1, 0, 4'd5), "post_dis2");
        apply(mk(16'h0000, 0, 1, 0, 4'd5), "post_dis3");
        apply(mk(16'h0000, 0, 1, 0, 4'd5), "post_dis4");
        apply(mk(16'h0000, 0, 0, 0, 4'd5), "post_dis5");

        // Random scans against the model, from a fresh reset.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        prev_keys = '0;
        for (int s = 0; s < 60; s++) begin
            r = $urandom_range(0, 9);
            if (r < 5) rnd_keys = prev_keys;
            else if (r < 7) rnd_keys = '0;
            else if (r < 9) rnd_keys = 16'(1) << $urandom_range(0, 15);
            else rnd_keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            prev_keys = rnd_keys;
            model_scan(rnd_keys);
            apply(mk(rnd_keys, m_valid, m_held, m_multi, m_code), $sformatf("rnd%0d", s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
